sel_arbiter: RTL and testbench
==============================

SEL_ARBITER -- requirements
Module: sel_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the accepted-transfer counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous assert and active-low, released synchronously to clk.
REQ-004 SHALL have port req, input, 4, request per source (bit0 = source a, bit1 = b, bit2 = c, bit3 = d).
REQ-005 SHALL have port ready, input, 1, downstream 4:1 data mux consumer accepts the current selection.
REQ-006 SHALL have port sel, output, 2, registered index of the granted source; drives the mux select.
REQ-007 SHALL have port grant, output, 4, registered one-hot grant; equals 1 << sel when valid, else 0.
REQ-008 SHALL have port valid, output, 1, registered; sel and grant hold a live selection.
REQ-009 SHALL have port count, output, CNT_W, number of accepted transfers, saturating at all-ones.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (valid=0) and BUSY (valid=1).
REQ-011 SHALL, in IDLE with req != 0, arbitrate and enter BUSY on the next edge with sel/grant loaded; latency req-to-valid = 1 cycle.
REQ-012 SHALL, in IDLE with req == 0, remain in IDLE with grant = 0 and sel unchanged.
REQ-013 SHALL hold sel, grant and valid stable in BUSY while ready = 0, regardless of req changes, including deassertion of the granted bit; no grant is revoked.
REQ-014 SHALL treat valid & ready in one cycle as a transfer: count increments by 1 unless already all-ones.
REQ-015 SHALL, on transfer with req != 0 that same cycle, re-arbitrate over current req and stay BUSY; back-to-back transfers sustain 1 per cycle.
REQ-016 SHALL, on transfer with req == 0, return to IDLE next edge with grant = 0 and valid = 0.
REQ-017 SHALL include the currently granted source's req bit in re-arbitration; the arbitration rule alone decides the winner.
REQ-018 SHALL keep an internal 2-bit priority pointer ptr, updated only on transfer to sel + 1 modulo 4 (wrap 3 -> 0).
REQ-019 SHALL ignore ready while in IDLE; count does not change.
REQ-020 SHALL compute grant combinationally from req and ptr, but register all outputs.

Reset
REQ-021 SHALL on rst_n = 0, immediately and independent of clk, force state = IDLE, sel = 0, grant = 0, valid = 0, ptr = 0, count = 0.
REQ-022 SHALL abandon any pending selection if reset asserts mid-BUSY; no transfer is counted for that cycle.
REQ-023 SHALL resume arbitration on the first rising edge after rst_n returns high.

Configuration
REQ-024 SHALL, with macro SEL_ARB_ROUND_ROBIN_EN defined, grant the first requesting source found scanning upward from ptr, wrapping 3 -> 0.
REQ-025 SHALL, without SEL_ARB_ROUND_ROBIN_EN, use fixed priority bit0 > bit1 > bit2 > bit3; ptr is still maintained but has no effect on the winner.

Verification
REQ-026 SHALL test reset: hold rst_n = 0 with req = 4'b1111 -> sel = 0, grant = 0, valid = 0, count = 0; release -> next edge valid = 1, sel = 0, grant = 4'b0001.
REQ-027 SHALL test stall: req = 4'b0100, ready = 0 for 5 cycles, drop req after cycle 2 -> sel = 2, grant = 4'b0100, valid = 1 held all 5 cycles; count = 0.
REQ-028 SHALL test rotation (ROUND_ROBIN_EN): req = 4'b1111, ready = 1 for 6 cycles -> sel sequence 0,1,2,3,0,1; count = 6.
REQ-029 SHALL test fixed priority (macro off): req = 4'b1111, ready = 1 for 4 cycles -> sel = 0 every cycle; req = 4'b1010 -> sel = 1.
REQ-030 SHALL test drain and saturation: CNT_W = 2, req = 4'b0001, ready = 1 for 5 cycles, then req = 0 -> count sticks at 3; after the last transfer, valid = 0 and grant = 0 the next cycle.
REQ-031 SHALL test reset mid-BUSY: valid = 1, sel = 3, ready = 1, async rst_n pulse between edges -> outputs clear immediately; count unchanged from pre-cycle value reset to 0.

Source files
------------

// File: rtl/sel_arbiter.sv
// -----------------------------------------------------------------------------
// sel_arbiter
//   Four-source arbiter that drives the select of a downstream 4:1 data mux.
//   IDLE waits for any request.
//   BUSY holds a live selection until the consumer accepts it with ready.
//   Every accepted transfer re-arbitrates over the current requests, so
//   back-to-back transfers run at one per cycle. The module keeps a
//   saturating count of accepted transfers.
//
//   Build option:
//     SEL_ARB_ROUND_ROBIN_EN  defined   -> round robin. The scan starts at the
//                                          priority pointer and wraps 3 -> 0.
//                             undefined -> fixed priority, bit0 highest.
//                                          The pointer is still updated but
//                                          does not affect the winner.
//
//   Ports:
//     clk    in   1      clock, rising edge
//     rst_n  in   1      async assert, active-low reset
//     req    in   4      request per source (bit0 = a .. bit3 = d)
//     ready  in   1      consumer accepts the current selection
//     sel    out  2      registered index of the granted source
//     grant  out  4      registered one-hot grant (0 when not valid)
//     valid  out  1      registered; sel/grant hold a live selection
//     count  out  CNT_W  accepted transfers, saturating at all-ones
// -----------------------------------------------------------------------------
module sel_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic             ready,
  output logic [1:0]       sel,
  output logic [3:0]       grant,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q;
  logic [1:0]       sel_q;
  logic [3:0]       grant_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             transfer;
  logic [1:0]       ptr_d;
  logic [1:0]       sel_d;
  logic [3:0]       grant_d;
  logic [CNT_W-1:0] count_d;

  // A transfer exists only while a selection is live. Ready is ignored in IDLE.
  assign transfer = (state_q == BUSY) && ready;

  // On a transfer the pointer moves past the source just served.
  // Re-arbitration in that same cycle uses the moved pointer, so a full
  // request set rotates 0,1,2,3.
  assign ptr_d = transfer ? (sel_q + 2'd1) : ptr_q;

  assign count_d = (transfer && (count_q != {CNT_W{1'b1}})) ? (count_q + 1'b1) : count_q;

`ifdef SEL_ARB_ROUND_ROBIN_EN
  // Scan downward in offset so that the last hit is the lowest offset from
  // the pointer. That hit is the first requester found scanning upward.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves it unassigned would infer a latch.
    sel_d = ptr_d;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_d + 2'(k)]) sel_d = ptr_d + 2'(k);
    end
  end
`else
  // Fixed priority: the lowest-numbered requester wins.
  always_comb begin
    sel_d = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) sel_d = 2'(k);
    end
  end

  // The pointer is still maintained in this build but has no effect on the
  // winner. This reference keeps it visibly part of the design.
  logic ptr_unused;
  assign ptr_unused = ^ptr_d;
`endif

  assign grant_d = 4'b0001 << sel_d;

  // FSM together with its registered outputs.
  // NOTE: asynchronous reset clears every state register here; there is no
  // memory array, so nothing is left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      grant_q <= 4'd0;
      ptr_q   <= 2'd0;
      count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side reads pre-edge values.
      ptr_q   <= ptr_d;
      count_q <= count_d;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= BUSY;
            sel_q   <= sel_d;
            grant_q <= grant_d;
          end else begin
            grant_q <= 4'd0;
          end
        end
        BUSY: begin
          // Without ready the selection is frozen: no grant is revoked, even
          // if the granted request drops.
          if (ready) begin
            if (|req) begin
              sel_q   <= sel_d;
              grant_q <= grant_d;
            end else begin
              state_q <= IDLE;
              grant_q <= 4'd0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 4'd0;
        end
      endcase
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign valid = (state_q == BUSY);
  assign count = count_q;

endmodule

// File: tb/tb_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sel_arbiter
//   Scoreboard bench for sel_arbiter. Each scenario task pushes the expected
//   post-edge outputs when it drives a cycle, then pops and compares them
//   after the edge.
//   A second instance with CNT_W = 2 shares all inputs. It observes
//   saturation of the transfer count.
// -----------------------------------------------------------------------------
module tb_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ready;

  logic [1:0] sel,   sel_s;
  logic [3:0] grant, grant_s;
  logic       valid, valid_s;
  logic [7:0] count;
  logic [1:0] count_s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic       chk_sel;
    logic [1:0] s;
    logic [3:0] g;
    logic [7:0] c;
    logic [1:0] cs;
  } exp_t;

  exp_t exp_q[$];

  sel_arbiter #(.CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .ready(ready),
    .sel  (sel),
    .grant(grant),
    .valid(valid),
    .count(count)
  );

  sel_arbiter #(.CNT_W(2)) dut_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .ready(ready),
    .sel  (sel_s),
    .grant(grant_s),
    .valid(valid_s),
    .count(count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs. The 2-bit instance saturates at 3.
  function automatic exp_t mk(input logic v, input logic chk_sel, input logic [1:0] s,
                              input logic [3:0] g, input logic [7:0] c);
    exp_t e;
    e.v       = v;
    e.chk_sel = chk_sel;
    e.s       = s;
    e.g       = g;
    e.c       = c;
    e.cs      = (c > 8'd3) ? 2'd3 : c[1:0];
    return e;
  endfunction

  // Apply the reset with the given inputs and release it on a falling edge.
  task automatic do_reset(input logic [3:0] r, input logic rdy);
    @(negedge clk);
    req   = r;
    ready = rdy;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    req   = 4'b1111;
    ready = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 4'b0000, 8'd0));
      else       exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 4'b0001, 8'd0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({valid, grant, count, count_s, valid_s, grant_s} !== {e.v, e.g, e.c, e.cs, e.v, e.g} ||
          (e.chk_sel && (sel !== e.s || sel_s !== e.s))) begin
        errors++;
        $display("FAIL reset[%0d]: got v=%b s=%0d g=%b c=%0d cs=%0d, want v=%b s=%0d g=%b c=%0d cs=%0d",
                 i, valid, sel, grant, count, count_s, e.v, e.s, e.g, e.c, e.cs);
      end
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
    end
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset(4'b0100, 1'b0);
    for (int i = 0; i < 8; i++) begin
      req   = (i < 3) ? 4'b0100 : 4'b0000;
      ready = (i >= 6);
      if (i < 6) exp_q.push_back(mk(1'b1, 1'b1, 2'd2, 4'b0100, 8'd0));
      else       exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 4'b0000, 8'd1));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({valid, grant, count, count_s, valid_s, grant_s} !== {e.v, e.g, e.c, e.cs, e.v, e.g} ||
          (e.chk_sel && (sel !== e.s || sel_s !== e.s))) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%b s=%0d g=%b c=%0d cs=%0d, want v=%b s=%0d g=%b c=%0d cs=%0d",
                 i, valid, sel, grant, count, count_s, e.v, e.s, e.g, e.c, e.cs);
      end
      @(negedge clk);
    end
  endtask

`ifdef SEL_ARB_ROUND_ROBIN_EN
  task automatic test_rotation();
    exp_t e;
    logic [1:0] s_exp [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    do_reset(4'b1111, 1'b0);
    for (int i = 0; i < 7; i++) begin
      req   = 4'b1111;
      ready = (i > 0);
      exp_q.push_back(mk(1'b1, 1'b1, s_exp[i], 4'b0001 << s_exp[i], 8'(i)));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({valid, grant, count, count_s, valid_s, grant_s} !== {e.v, e.g, e.c, e.cs, e.v, e.g} ||
          (e.chk_sel && (sel !== e.s || sel_s !== e.s))) begin
        errors++;
        $display("FAIL rotation[%0d]: got v=%b s=%0d g=%b c=%0d cs=%0d, want v=%b s=%0d g=%b c=%0d cs=%0d",
                 i, valid, sel, grant, count, count_s, e.v, e.s, e.g, e.c, e.cs);
      end
      @(negedge clk);
    end
  endtask
`else
  task automatic test_fixed_priority();
    exp_t e;
    logic [3:0] rq    [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1010, 4'b1011};
    logic [1:0] s_exp [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    do_reset(4'b1111, 1'b0);
    for (int i = 0; i < 7; i++) begin
      req   = rq[i];
      ready = (i > 0);
      exp_q.push_back(mk(1'b1, 1'b1, s_exp[i], 4'b0001 << s_exp[i], 8'(i)));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({valid, grant, count, count_s, valid_s, grant_s} !== {e.v, e.g, e.c, e.cs, e.v, e.g} ||
          (e.chk_sel && (sel !== e.s || sel_s !== e.s))) begin
        errors++;
        $display("FAIL fixed[%0d]: got v=%b s=%0d g=%b c=%0d cs=%0d, want v=%b s=%0d g=%b c=%0d cs=%0d",
                 i, valid, sel, grant, count, count_s, e.v, e.s, e.g, e.c, e.cs);
      end
      @(negedge clk);
    end
  endtask
`endif

  // One arbitration cycle and four transfers with req = 0001, then a drain
  // transfer with req = 0, then one more idle cycle with ready high.
  task automatic test_drain_saturation();
    exp_t e;
    do_reset(4'b0001, 1'b1);
    for (int i = 0; i < 7; i++) begin
      req   = (i < 5) ? 4'b0001 : 4'b0000;
      ready = 1'b1;
      if (i < 5) exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 4'b0001, 8'(i)));
      else       exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 4'b0000, 8'd5));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({valid, grant, count, count_s, valid_s, grant_s} !== {e.v, e.g, e.c, e.cs, e.v, e.g} ||
          (e.chk_sel && (sel !== e.s || sel_s !== e.s))) begin
        errors++;
        $display("FAIL drain_sat[%0d]: got v=%b s=%0d g=%b c=%0d cs=%0d, want v=%b s=%0d g=%b c=%0d cs=%0d",
                 i, valid, sel, grant, count, count_s, e.v, e.s, e.g, e.c, e.cs);
      end
      @(negedge clk);
    end
  endtask

  // Steps: 0 grant sel 3; 1 transfer; 2 async reset between edges;
  // 3 the edge still in reset; 4 after release; 5 a transfer after reset.
  task automatic test_reset_mid_busy();
    exp_t e;
    do_reset(4'b1000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      req   = 4'b1000;
      ready = (i > 0);
      case (i)
        0:       exp_q.push_back(mk(1'b1, 1'b1, 2'd3, 4'b1000, 8'd0));
        1:       exp_q.push_back(mk(1'b1, 1'b1, 2'd3, 4'b1000, 8'd1));
        2, 3:    exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 4'b0000, 8'd0));
        4:       exp_q.push_back(mk(1'b1, 1'b1, 2'd3, 4'b1000, 8'd0));
        default: exp_q.push_back(mk(1'b1, 1'b1, 2'd3, 4'b1000, 8'd1));
      endcase
      if (i == 2) begin
        #2 rst_n = 1'b0;
        #1;
      end else begin
        @(posedge clk); #1;
      end
      e = exp_q.pop_front();
      checks++;
      if ({valid, grant, count, count_s, valid_s, grant_s} !== {e.v, e.g, e.c, e.cs, e.v, e.g} ||
          (e.chk_sel && (sel !== e.s || sel_s !== e.s))) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got v=%b s=%0d g=%b c=%0d cs=%0d, want v=%b s=%0d g=%b c=%0d cs=%0d",
                 i, valid, sel, grant, count, count_s, e.v, e.s, e.g, e.c, e.cs);
      end
      if (i != 2) @(negedge clk);
      if (i == 3) rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    test_reset();
    test_stall();
`ifdef SEL_ARB_ROUND_ROBIN_EN
    test_rotation();
`else
    test_fixed_priority();
`endif
    test_drain_saturation();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
